// File: rtl/rf_write_arbiter_pkg.sv
// Shared register-file constants: data/index widths, register count, x0 index and writeback requester slots.
package rf_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int REG_X0   = 0;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_CSR  = 2;
endpackage

// File: rtl/rf_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer moves to the winner at posedge.
// Latency: grant in the same cycle as the request; no backpressure of its own (pointer holds when idle).
module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] win_idx;
    logic             win_any;

    // Search starts one past the last winner; wrap is an explicit compare so non-power-of-two counts work.
    always_comb begin
        grant   = '0;
        idx     = ptr;
        win_idx = ptr;
        win_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (idx == LAST) ? '0 : idx + PTR_W'(1);
            if (!win_any && req[idx]) begin
                win_any = 1'b1;
                win_idx = idx;
            end
        end
        if (win_any) grant[win_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= LAST;
        end else if (win_any) begin
            ptr <= win_idx;
        end
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback sources and tracks pending destinations.
// Latency: grant at t, rf_* valid at t+1; never stalls, so one write is accepted every cycle.
module rf_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = rf_pkg::DATA_W,
    parameter int ADDR_W  = rf_pkg::ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rf_reg_write,
    output logic [ADDR_W-1:0]         rf_write_register,
    output logic [DATA_W-1:0]         rf_write_data,
    input  logic                      rsv_valid,
    input  logic [ADDR_W-1:0]         rsv_addr,
    input  logic [ADDR_W-1:0]         rs1_addr,
    input  logic [ADDR_W-1:0]         rs2_addr,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    output logic [(2**ADDR_W)-1:0]    pending
);
    import rf_pkg::*;

    localparam logic [ADDR_W-1:0] X0 = ADDR_W'(REG_X0);

    logic [NUM_REQ-1:0]     grant;
    logic                   grant_any;
    logic [ADDR_W-1:0]      sel_addr;
    logic [DATA_W-1:0]      sel_data;
    logic                   sel_write;
    logic [(2**ADDR_W)-1:0] pending_nxt;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk   (clk),
        .rst   (rst),
        .req   (req_valid),
        .grant (grant)
    );

    assign req_ready = grant;
    assign grant_any = |grant;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // x0 writes are accepted from the requester but never reach the register file.
    assign sel_write = grant_any && (sel_addr != X0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_reg_write      <= 1'b0;
            rf_write_register <= '0;
            rf_write_data     <= '0;
        end else begin
            rf_reg_write <= sel_write;
            if (sel_write) begin
                rf_write_register <= sel_addr;
                rf_write_data     <= sel_data;
            end
        end
    end

    // Clear before set so a reservation made on the commit edge survives.
    always_comb begin
        pending_nxt = pending;
        if (rf_reg_write) pending_nxt[rf_write_register] = 1'b0;
        if (rsv_valid && (rsv_addr != X0)) pending_nxt[rsv_addr] = 1'b1;
        pending_nxt[REG_X0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign rs1_busy = pending[rs1_addr];
    assign rs2_busy = pending[rs2_addr];
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: arbitration order, output stage timing, x0 filter, scoreboard and reset.
module tb_rf_write_arbiter;
    import rf_pkg::*;

    localparam int NR = 3;
    localparam int DW = 32;
    localparam int AW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              rf_reg_write;
    logic [AW-1:0]     rf_write_register;
    logic [DW-1:0]     rf_write_data;
    logic              rsv_valid;
    logic [AW-1:0]     rsv_addr;
    logic [AW-1:0]     rs1_addr;
    logic [AW-1:0]     rs2_addr;
    logic              rs1_busy;
    logic              rs2_busy;
    logic [(2**AW)-1:0] pending;

    int checks   = 0;
    int failures = 0;

    rf_write_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_addr          (req_addr),
        .req_data          (req_data),
        .req_ready         (req_ready),
        .rf_reg_write      (rf_reg_write),
        .rf_write_register (rf_write_register),
        .rf_write_data     (rf_write_data),
        .rsv_valid         (rsv_valid),
        .rsv_addr          (rsv_addr),
        .rs1_addr          (rs1_addr),
        .rs2_addr          (rs2_addr),
        .rs1_busy          (rs1_busy),
        .rs2_busy          (rs2_busy),
        .pending           (pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_addr[i*AW +: AW]  = a;
        req_data[i*DW +: DW]  = d;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
        rsv_valid = 1'b0; rsv_addr = '0; rs1_addr = '0; rs2_addr = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_we", 32'(rf_reg_write), 32'd0);
        chk("rst_reg", 32'(rf_write_register), 32'd0);
        chk("rst_data", rf_write_data, 32'd0);
        chk("rst_pending", pending, 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);

        // Single requester: LOAD writes x5.
        set_req(REQ_LOAD, 1'b1, 5'd5, 32'hDEADBEEF);
        #1 chk("t1_ready", 32'(req_ready), 32'b010);
        tick();
        req_valid = '0;
        #1;
        chk("t1_we", 32'(rf_reg_write), 32'd1);
        chk("t1_reg", 32'(rf_write_register), 32'd5);
        chk("t1_data", rf_write_data, 32'hDEADBEEF);
        chk("t1_idle_ready", 32'(req_ready), 32'd0);
        tick();
        chk("t1_we_off", 32'(rf_reg_write), 32'd0);
        chk("t1_hold_reg", 32'(rf_write_register), 32'd5);
        chk("t1_hold_data", rf_write_data, 32'hDEADBEEF);

        // Full contention straight after reset.
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, AW'(i + 1), 32'hA000_0000 + 32'(i));
        for (int c = 0; c < 6; c++) begin
            #1 chk($sformatf("t2_ready_c%0d", c), 32'(req_ready), 32'(1 << (c % 3)));
            tick();
            chk($sformatf("t2_we_c%0d", c), 32'(rf_reg_write), 32'd1);
            chk($sformatf("t2_reg_c%0d", c), 32'(rf_write_register), 32'((c % 3) + 1));
        end
        req_valid = '0;
        tick();
        chk("t2_we_off", 32'(rf_reg_write), 32'd0);

        // x0 write: move pointer to 1, then CSR writes x0; pointer must reach 2.
        set_req(REQ_LOAD, 1'b1, 5'd4, 32'h0000_4444);
        tick();
        req_valid = '0;
        set_req(REQ_CSR, 1'b1, 5'd0, 32'h12345678);
        #1 chk("t3_ready", 32'(req_ready), 32'b100);
        tick();
        req_valid = '0;
        #1;
        chk("t3_we", 32'(rf_reg_write), 32'd0);
        chk("t3_hold_reg", 32'(rf_write_register), 32'd4);
        chk("t3_hold_data", rf_write_data, 32'h0000_4444);
        req_valid = 3'b111;
        #1 chk("t3_ptr_adv", 32'(req_ready), 32'b001);
        req_valid = '0;
        tick();

        // Reserve x7, commit it three cycles later.
        rs1_addr = 5'd7; rsv_valid = 1'b1; rsv_addr = 5'd7;
        #1 chk("t4_busy_pre", 32'(rs1_busy), 32'd0);
        tick();
        rsv_valid = 1'b0;
        #1;
        chk("t4_busy_r1", 32'(rs1_busy), 32'd1);
        chk("t4_pend_r1", pending, 32'h0000_0080);
        tick();
        chk("t4_busy_r2", 32'(rs1_busy), 32'd1);
        tick();
        set_req(REQ_ALU, 1'b1, 5'd7, 32'h0000_00AA);
        #1 chk("t4_ready", 32'(req_ready), 32'b001);
        tick();
        req_valid = '0;
        #1;
        chk("t4_commit_we", 32'(rf_reg_write), 32'd1);
        chk("t4_busy_commit", 32'(rs1_busy), 32'd1);
        tick();
        chk("t4_busy_after", 32'(rs1_busy), 32'd0);
        chk("t4_pend_after", pending, 32'd0);

        // Reserve x9 on the same edge x9 commits; also try reserving x0.
        rs2_addr = 5'd9;
        set_req(REQ_ALU, 1'b1, 5'd9, 32'h0000_0999);
        tick();
        req_valid = '0;
        rsv_valid = 1'b1; rsv_addr = 5'd9;
        #1;
        chk("t5_commit_we", 32'(rf_reg_write), 32'd1);
        chk("t5_busy_pre", 32'(rs2_busy), 32'd0);
        tick();
        rsv_addr = 5'd0;
        #1 chk("t5_pend9", pending, 32'h0000_0200);
        tick();
        rsv_valid = 1'b0;
        #1;
        chk("t5_x0_pend", pending, 32'h0000_0200);
        chk("t5_busy2", 32'(rs2_busy), 32'd1);

        // Reset while a write is in flight and x3/x7 are pending.
        rsv_valid = 1'b1; rsv_addr = 5'd3;
        tick();
        rsv_addr = 5'd7;
        tick();
        rsv_valid = 1'b0;
        set_req(REQ_ALU, 1'b1, 5'd12, 32'h0000_0C0C);
        tick();
        req_valid = '0;
        #1;
        chk("t6_we_pre", 32'(rf_reg_write), 32'd1);
        chk("t6_pend_pre", pending, 32'h0000_0288);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t6_we_post", 32'(rf_reg_write), 32'd0);
        chk("t6_pend_post", pending, 32'd0);
        req_valid = 3'b111;
        #1 chk("t6_ready_post", 32'(req_ready), 32'b001);
        req_valid = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
